// File: rtl/mem_pkg.sv
// Shared constants for the data-memory responder:
// FSM state codes, word geometry and latency counter width.
package mem_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int WORD_BYTES = 4;
   localparam int CNT_W      = 4;

endpackage

// File: rtl/data_mem_array.sv
// Word storage: synchronous write, combinational read.
// Contents have no reset and survive responder resets.
module data_mem_array #(
   parameter  int WORDS = 1024,
   localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic          clock,
   input  logic          wen,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   din,
   output logic [31:0]   dout
);

   logic [31:0] mem [WORDS];

   always_ff @(posedge clock) begin
      if (wen) mem[addr] <= din;
   end

   assign dout = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked multi-cycle load/store responder with fixed latency,
// alignment/range checking and a single outstanding request.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int DATA_MEM_SIZE = 4096,
   parameter int LATENCY       = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_wen,
   input  logic [31:0] req_din,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_dout,
   output logic        resp_err
);

   localparam int WORDS = DATA_MEM_SIZE / WORD_BYTES;
   localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [31:0] MEM_BYTES = 32'(DATA_MEM_SIZE);

   logic [1:0]       state;
   logic [1:0]       state_nx;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      addr_q;
   logic [31:0]      din_q;
   logic             wen_q;

   logic        accept;
   logic        commit;
   logic [31:0] c_addr;
   logic [31:0] c_din;
   logic        c_wen;
   logic        c_err;
   logic        mem_wen;
   logic [31:0] mem_rd;

   assign accept     = req_valid & req_ready;
   assign resp_valid = (state == ST_RESP);
   assign commit     = (state_nx == ST_RESP) & (state != ST_RESP);

   // With LATENCY=1 the commit coincides with the accept edge,
   // so the request is taken straight from the ports.
   assign c_addr = (state == ST_IDLE) ? req_addr : addr_q;
   assign c_din  = (state == ST_IDLE) ? req_din  : din_q;
   assign c_wen  = (state == ST_IDLE) ? req_wen  : wen_q;

   assign c_err   = (c_addr[1:0] != 2'b00) | (c_addr >= MEM_BYTES);
   assign mem_wen = commit & c_wen & ~c_err;

   data_mem_array #(.WORDS(WORDS)) u_array (
      .clock (clock),
      .wen   (mem_wen),
      .addr  (c_addr[AW+1:2]),
      .din   (c_din),
      .dout  (mem_rd)
   );

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: begin
            if (accept) state_nx = (LATENCY > 1) ? ST_WAIT : ST_RESP;
         end
         ST_WAIT: begin
            if (cnt == CNT_W'(1)) state_nx = ST_RESP;
         end
         ST_RESP: begin
            if (resp_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         req_ready <= 1'b0;
         cnt       <= '0;
         addr_q    <= '0;
         din_q     <= '0;
         wen_q     <= 1'b0;
         resp_dout <= '0;
         resp_err  <= 1'b0;
      end else begin
         state     <= state_nx;
         req_ready <= (state_nx == ST_IDLE);
         if (accept) begin
            addr_q <= req_addr;
            din_q  <= req_din;
            wen_q  <= req_wen;
            cnt    <= CNT_W'(LATENCY - 1);
         end else if (state == ST_WAIT) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (commit) begin
            resp_err  <= c_err;
            resp_dout <= (!c_wen && !c_err) ? mem_rd : 32'h0;
         end else if (resp_valid && resp_ready) begin
            resp_err  <= 1'b0;
            resp_dout <= 32'h0;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 4, 1)
// checked against a word-array reference model.
module tb_data_mem_responder;

   localparam int ND = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid  [ND];
   logic        req_ready  [ND];
   logic [31:0] req_addr   [ND];
   logic        req_wen    [ND];
   logic [31:0] req_din    [ND];
   logic        resp_valid [ND];
   logic        resp_ready [ND];
   logic [31:0] resp_dout  [ND];
   logic        resp_err   [ND];

   logic [31:0] mdl   [ND][1024];
   bit          known [ND][1024];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      data_mem_responder #(
         .DATA_MEM_SIZE (4096),
         .LATENCY       (g == 0 ? 2 : (g == 1 ? 4 : 1))
      ) u_dut (
         .clock      (clock),
         .reset      (reset),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_addr   (req_addr[g]),
         .req_wen    (req_wen[g]),
         .req_din    (req_din[g]),
         .resp_valid (resp_valid[g]),
         .resp_ready (resp_ready[g]),
         .resp_dout  (resp_dout[g]),
         .resp_err   (resp_err[g])
      );
   end

   function automatic int lat_of(int d);
      return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One complete request/response exchange with `stall` cycles of
   // response backpressure, checked against the model.
   task automatic txn(int d, bit wen, logic [31:0] a,
                      logic [31:0] din, int stall);
      int          n;
      bit          err;
      bit          chk_data;
      logic [31:0] exp;
      logic [31:0] d0;
      logic        e0;
      @(negedge clock);
      n = 0;
      while (!req_ready[d] && n < 20) begin
         @(negedge clock);
         n++;
      end
      check($sformatf("ready_d%0d", d), 32'(req_ready[d]), 32'd1);
      req_valid[d]  = 1'b1;
      req_wen[d]    = wen;
      req_addr[d]   = a;
      req_din[d]    = din;
      resp_ready[d] = 1'b0;
      @(posedge clock);
      @(negedge clock);
      req_valid[d] = 1'b0;
      n = 1;
      while (!resp_valid[d] && n < 20) begin
         @(negedge clock);
         n++;
      end
      check($sformatf("latency_d%0d", d), 32'(n), 32'(lat_of(d)));
      err = (a[1:0] != 2'b00) || (a >= 32'd4096);
      chk_data = 1'b1;
      exp = 32'h0;
      if (!wen && !err) begin
         chk_data = known[d][a[11:2]];
         exp = mdl[d][a[11:2]];
      end
      if (wen && !err) begin
         mdl[d][a[11:2]]   = din;
         known[d][a[11:2]] = 1'b1;
      end
      check($sformatf("err_d%0d_%h", d, a), 32'(resp_err[d]), 32'(err));
      if (chk_data)
         check($sformatf("dout_d%0d_%h", d, a), resp_dout[d], exp);
      d0 = resp_dout[d];
      e0 = resp_err[d];
      for (int s = 0; s < stall; s++) begin
         @(negedge clock);
         check("hold_valid", 32'(resp_valid[d]), 32'd1);
         check("hold_dout", resp_dout[d], d0);
         check("hold_err", 32'(resp_err[d]), 32'(e0));
         check("hold_ready", 32'(req_ready[d]), 32'd0);
      end
      resp_ready[d] = 1'b1;
      @(posedge clock);
      @(negedge clock);
      resp_ready[d] = 1'b0;
      check("post_valid", 32'(resp_valid[d]), 32'd0);
      check("post_ready", 32'(req_ready[d]), 32'd1);
      check("post_dout", resp_dout[d], 32'h0);
      check("post_err", 32'(resp_err[d]), 32'd0);
   endtask

   initial begin
      int          n;
      int          k;
      int          acc;
      int          nresp;
      int          last;
      bit          pend;
      logic [31:0] a;
      for (int d = 0; d < ND; d++) begin
         req_valid[d]  = 1'b0;
         req_addr[d]   = '0;
         req_wen[d]    = 1'b0;
         req_din[d]    = '0;
         resp_ready[d] = 1'b0;
         for (int w = 0; w < 1024; w++) known[d][w] = 1'b0;
      end

      // Reset held three cycles, then released.
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         for (int d = 0; d < ND; d++)
            check("rst_ready", 32'(req_ready[d]), 32'd0);
      end
      reset = 1'b1;
      #1;
      for (int d = 0; d < ND; d++)
         check("rel_ready", 32'(req_ready[d]), 32'd0);
      @(negedge clock);
      for (int d = 0; d < ND; d++) begin
         check("init_ready", 32'(req_ready[d]), 32'd1);
         check("init_valid", 32'(resp_valid[d]), 32'd0);
         check("init_dout", resp_dout[d], 32'h0);
         check("init_err", 32'(resp_err[d]), 32'd0);
      end

      // Directed sequence on the LATENCY=2 instance.
      txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
      txn(0, 1'b0, 32'h10, 32'h0, 5);
      txn(0, 1'b1, 32'h13, 32'h0BADF00D, 0);
      txn(0, 1'b0, 32'h10, 32'h0, 1);
      txn(0, 1'b0, 32'h1000, 32'h0, 0);
      txn(0, 1'b0, 32'hFFC, 32'h0, 0);
      txn(0, 1'b1, 32'hFFC, 32'hCAFE0001, 0);
      txn(0, 1'b0, 32'hFFC, 32'h0, 2);

      // Reset during WAIT on the LATENCY=4 instance drops the write.
      txn(1, 1'b1, 32'h20, 32'h0, 0);
      @(negedge clock);
      req_valid[1] = 1'b1;
      req_wen[1]   = 1'b1;
      req_addr[1]  = 32'h20;
      req_din[1]   = 32'h12345678;
      @(posedge clock);
      @(negedge clock);
      req_valid[1] = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         check("abort_valid", 32'(resp_valid[1]), 32'd0);
      end
      reset = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         check("abort_noresp", 32'(resp_valid[1]), 32'd0);
      end
      txn(1, 1'b0, 32'h20, 32'h0, 0);

      // Back-to-back reads on the LATENCY=1 instance.
      for (int w = 0; w < 4; w++)
         txn(2, 1'b1, 32'h40 + 32'(4 * w), $urandom, 0);
      @(negedge clock);
      req_valid[2]  = 1'b1;
      req_wen[2]    = 1'b0;
      req_addr[2]   = 32'h40;
      resp_ready[2] = 1'b1;
      acc = 0;
      nresp = 0;
      last = -10;
      k = 0;
      while (nresp < 4 && k < 30) begin
         pend = 1'b0;
         if (resp_valid[2]) begin
            check("b2b_lat", 32'(k - last), 32'd1);
            a = 32'h40 + 32'(4 * (acc - 1));
            check("b2b_dout", resp_dout[2], mdl[2][a[11:2]]);
            nresp++;
         end
         if (req_valid[2] && req_ready[2]) begin
            if (acc > 0) check("b2b_space", 32'(k - last), 32'd2);
            last = k;
            acc++;
            pend = 1'b1;
         end
         @(posedge clock);
         @(negedge clock);
         k++;
         if (pend) begin
            if (acc < 4) req_addr[2] = 32'h40 + 32'(4 * acc);
            else req_valid[2] = 1'b0;
         end
      end
      req_valid[2]  = 1'b0;
      resp_ready[2] = 1'b0;
      check("b2b_count", 32'(nresp), 32'd4);

      // Randomized traffic on every instance.
      for (int d = 0; d < ND; d++) begin
         for (int t = 0; t < 25; t++) begin
            n = $urandom_range(0, 9);
            if (n < 3) a = 32'(4 * $urandom_range(0, 15));
            else if (n < 6) a = 32'hFC0 + 32'(4 * $urandom_range(0, 15));
            else if (n < 8)
               a = 32'(4 * $urandom_range(0, 1023)) + 32'($urandom_range(1, 3));
            else if (n < 9) a = 32'h1000 + 32'(4 * $urandom_range(0, 100));
            else a = 32'hFFFF_FFFC;
            txn(d, 1'($urandom_range(0, 1)), a, $urandom,
                $urandom_range(0, 3));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
